// File: rtl/traffic_pkg.sv
// traffic_pkg: interval encodings, defaults and timer states shared with stateMachine
package traffic_pkg;
  localparam int INTERVAL_W = 4;
  typedef enum logic [1:0] {T_BASE = 2'b00, T_EXT = 2'b01, T_YEL = 2'b10, T_WALK = 2'b11} time_param_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} timer_state_e;
  localparam logic [INTERVAL_W-1:0] DEF_BASE = 4'd6;
  localparam logic [INTERVAL_W-1:0] DEF_EXT = 4'd3;
  localparam logic [INTERVAL_W-1:0] DEF_YEL = 4'd2;
  localparam logic [INTERVAL_W-1:0] DEF_WALK = 4'd3;
  function automatic logic [INTERVAL_W-1:0] default_interval(input logic [1:0] sel);
    return sel == T_BASE ? DEF_BASE : sel == T_EXT ? DEF_EXT : sel == T_YEL ? DEF_YEL : DEF_WALK;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: one-second prescaler with sync clear; TIMER_FAST_SIM_EN makes every enabled cycle a tick
module tick_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int DIV_W = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
`ifdef TIMER_FAST_SIM_EN
  assign tick = en;
`else
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = en && cnt_q == DIV_W'(CLK_HZ - 1);
    cnt_d = (clr || !en || tick) ? '0 : cnt_q + DIV_W'(1);
  end
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: rtl/traffic_interval_timer.sv
// traffic_interval_timer: programmable interval countdown with expired pulse (TIMER_FAST_SIM_EN via tick_gen)
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DIV_W = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startTimer,
  input  logic [1:0]            timeParameter,
  input  logic                  reprogram,
  input  logic                  progWe,
  input  logic [1:0]            progSel,
  input  logic [INTERVAL_W-1:0] progValue,
  output logic                  expired,
  output logic                  busy,
  output logic [INTERVAL_W-1:0] remaining
);
  timer_state_e state_q, state_d;
  logic [INTERVAL_W-1:0] rem_q, rem_d, sel_val, load_val;
  logic [INTERVAL_W-1:0] regs_q [4];
  logic [INTERVAL_W-1:0] regs_d [4];
  logic tick, clr;
  tick_gen #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W)) u_tick (
    .clk(clk), .reset(reset), .en(state_q == S_RUN), .clr(clr), .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    regs_d = regs_q;
    clr = 1'b0;
    sel_val = regs_q[timeParameter];
    load_val = sel_val == '0 ? INTERVAL_W'(1) : sel_val;
    if (reprogram) begin
      state_d = S_IDLE;
      rem_d = '0;
      clr = 1'b1;
      for (int i = 0; i < 4; i++) regs_d[i] = default_interval(2'(i));
    end else begin
      if (progWe) regs_d[progSel] = progValue;
      // the load reads regs_q, so a same-cycle write only affects later starts
      if (startTimer) begin
        state_d = S_RUN;
        rem_d = load_val;
        clr = 1'b1;
      end else if (state_q == S_RUN && tick) begin
        rem_d = rem_q - INTERVAL_W'(1);
        state_d = rem_q == INTERVAL_W'(1) ? S_DONE : S_RUN;
      end else if (state_q == S_DONE) begin
        state_d = S_IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= default_interval(2'(i));
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      regs_q <= regs_d;
    end
  end
  assign expired = state_q == S_DONE;
  assign busy = state_q == S_RUN;
  assign remaining = rem_q;
endmodule

// File: doc/traffic_interval_timer.md
# traffic_interval_timer

Responder side of the traffic controller's timer handshake. `stateMachine` issues `startTimer` with a 2-bit `timeParameter`; this block counts that many seconds and returns a one-cycle `expired` pulse. It holds the four programmable interval registers, restores their defaults on `reprogram`, and derives the 1 Hz tick from the 50 MHz system clock.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: clock cycles per one-second tick.
- `DIV_W`, 26: prescaler width; must satisfy 2^DIV_W ≥ CLK_HZ.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `startTimer`  in  1  one-cycle request to load and start a countdown.
- `timeParameter`  in  2  interval select: 00 base, 01 extended, 10 yellow, 11 walk.
- `reprogram`  in  1  restore all interval registers to defaults and abort any countdown.
- `progWe`  in  1  write strobe for one interval register.
- `progSel`  in  2  register to write, using the same encoding as `timeParameter`.
- `progValue`  in  4  seconds to write.
- `expired`  out  1  one-cycle pulse when the countdown completes.
- `busy`  out  1  high while counting.
- `remaining`  out  4  seconds left in the countdown; 0 when idle.

## Operation
- Interval registers are 4-bit, unsigned, in seconds. Defaults: base 6, extended 3, yellow 2, walk 3.
- A stored or loaded value of 0 is treated as 1 second, so a countdown never completes in zero time.
- FSM states:
  - IDLE: `busy`=0, `remaining`=0.
    - `startTimer` loads `remaining` from the selected register, clears the prescaler, and moves to RUN.
  - RUN: the prescaler counts 0..CLK_HZ-1.
    - At the terminal count it wraps to 0 and `remaining` decrements.
    - When `remaining`==1 and the tick occurs, the next state is DONE and `remaining` becomes 0.
  - DONE: `expired`=1 for one cycle, then unconditional return to IDLE.
- `startTimer` in RUN or DONE restarts the countdown from the newly selected register. A DONE pulse already registered still completes. No second pulse is produced for the aborted countdown.
- `reprogram`, sampled high:
  - restores defaults,
  - forces IDLE,
  - clears `remaining` and the prescaler,
  - suppresses `expired` on the following cycle.
- Priority, highest first: reset, `reprogram`, `startTimer`, `progWe`.
- `progWe` writes in any state. If it writes in the same cycle as `startTimer`, the load uses the old register value.
- A write to the register currently counting does not change the active countdown.
- `progWe` together with `reprogram`: the write is dropped.
- `timeParameter` is sampled only on the `startTimer` cycle.

## Timing
- Reset values:
  - `expired`=0, `busy`=0, `remaining`=0,
  - prescaler=0, FSM=IDLE,
  - all interval registers at defaults.
- If `startTimer` is sampled at edge E0 with a selected value of N (N ≥ 1):
  - `busy`=1 from E0.
  - `remaining` steps N, N-1, … at E0 + k·CLK_HZ.
  - `expired` is high for exactly the cycle starting at E0 + N·CLK_HZ.
  - `busy` falls at that same edge.
- All outputs are registered. There is no combinational path from any input to any output.
- Register writes are visible to a `startTimer` on the following cycle.

## Configuration
- `TIMER_FAST_SIM_EN`:
  - Defined: the prescaler is removed and every clock cycle counts as a one-second tick, i.e. CLK_HZ is effectively 1. `expired` then rises at E0 + N cycles. Used for simulation at 20 ns clock periods.
  - Undefined: the full CLK_HZ divider is used for synthesis.

## Structure
- Shared package `traffic_pkg` holds:
  - the `timeParameter` encodings (T_BASE, T_EXT, T_YEL, T_WALK),
  - default interval constants,
  - the interval width (4).
  
  `stateMachine` imports the same package.
- One sub-module, `tick_gen`: the prescaler with a synchronous clear, emitting a one-cycle `tick`. It contains the `TIMER_FAST_SIM_EN` bypass.
- The FSM and the register file stay in `traffic_interval_timer`.

## Test plan
All scenarios run with `TIMER_FAST_SIM_EN` defined.
- Reset low for 2 cycles → `expired`=0, `busy`=0, `remaining`=0; a base countdown then expires 6 cycles after start.
- `startTimer` with 10 (yellow) at E0 → `remaining` reads 2, 1, 0; `expired` is high only in the cycle starting at E0+2.
- `progWe` with sel 01 and value 9, then start with 01 → `expired` at E0+9. Start with `progValue` 0 → `expired` at E0+1.
- Start 00 at E0, then start 10 at E0+3 → single `expired` at E0+5; nothing at E0+6.
- Start 00, `reprogram` at E0+2 → `busy`=0 next cycle, no `expired`; after writing yellow=7 then `reprogram`, a yellow start expires at +2.
- `reprogram` and `startTimer` in the same cycle → remains IDLE. `progWe` and `startTimer` on the same register → old value is used.
